instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the core control decoder.
- Owns the program counter and runs a req/ack handshake with instruction memory.
- Holds the fetched instruction and exposes the decoder's inputs: op_code = instr[6:2], sub_op_code = {instr[30], instr[14:12]}.
- Consumes the decoder's pc_control encoding plus the branch result to pick the next PC, and halts on faults.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; first fetch address.
- NOP_INSTR, 32'h0000_0013, value held in the instruction register when no valid instruction is present (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request, registered.
- imem_addr  out  32  fetch address; equals pc.
- imem_ack  in  1  memory returns imem_rdata this cycle.
- imem_rdata  in  32  fetched instruction word.
- instr_valid  out  1  instr/op_code/sub_op_code are valid for execution.
- instr_ready  in  1  core finished executing the current instruction; next-PC inputs are valid.
- instr  out  32  instruction register.
- op_code  out  5  instr[6:2].
- sub_op_code  out  4  {instr[30], instr[14:12]}.
- pc  out  32  address of the current instruction.
- pc_plus4  out  32  pc + 4, for the link write.
- pc_control  in  2  01 = sequential, 10 = jump, 11 = branch, 00 = stop.
- branch_taken  in  1  branch comparison result; used only when pc_control = 11.
- target_addr  in  32  jump/branch target.
- misalign_fault  out  1  sticky: redirect target was not 4-byte aligned.
- illegal_fault  out  1  sticky: fetched word had instr[1:0] != 2'b11.
- halted  out  1  FSM is in HALT.

Behaviour:
- Reset (async assert; deassert synchronised by design), all values:
  - state = START, pc = RESET_PC, instr = NOP_INSTR.
  - imem_req = 0, instr_valid = 0, both faults = 0, halted = 0.
  - Therefore op_code = 5'b00100 and sub_op_code = 4'b0000.
- Reset mid-transaction abandons the outstanding request. Any late imem_ack after reset is ignored until the unit is back in FETCH.
- FSM states: START, FETCH, ISSUE, HALT.
- START: lasts one cycle; next state FETCH with imem_req = 1.
- FETCH: imem_req = 1.
  - imem_addr = pc, held stable until ack.
  - On imem_ack: instr <= imem_rdata, imem_req <= 0.
  - If imem_rdata[1:0] != 2'b11: set illegal_fault, go HALT, instr <= NOP_INSTR.
  - Otherwise instr_valid <= 1 and go ISSUE.
  - Ack can arrive in the first FETCH cycle, so minimum fetch latency is 1 cycle after req.
- ISSUE: instr_valid = 1; instr and pc are held stable.
  - The unit waits for instr_ready. On instr_ready it computes next_pc:
    - 01: pc + 4.
    - 10: {target_addr[31:1], 1'b0} (JALR bit-0 clear).
    - 11: branch_taken ? {target_addr[31:1], 1'b0} : pc + 4.
    - 00: no fetch; go HALT, pc unchanged.
  - Redirect with next_pc[1] = 1: set misalign_fault, go HALT, pc unchanged.
  - Otherwise pc <= next_pc, instr_valid <= 0, imem_req <= 1, go FETCH.
- Throughput: minimum 2 cycles per instruction (FETCH with same-cycle ack, then ISSUE with instr_ready = 1).
- HALT: imem_req = 0, instr_valid = 0, halted = 1.
  - Faults are sticky. Only reset leaves HALT.
- imem_ack outside FETCH is ignored.
- pc_control, branch_taken and target_addr are sampled only when ISSUE and instr_ready are both high.
- Arithmetic: pc + 4 is modulo 2^32; pc = 32'hFFFF_FFFC wraps to 0 with no fault.
- pc_plus4 is combinational from pc.

Test Plan:
1. Reset, then imem_ack every FETCH cycle; words at 0x0, 0x4, 0x8 with pc_control = 01 → requests at 0x0, 0x4, 0x8, instr_valid pulses every 2nd cycle, op_code and sub_op_code match instr fields.
2. Fetch 0x00A00093 at pc 0x10, pc_control = 11, branch_taken = 1, target 0x40 → next imem_addr = 0x40. Repeat with branch_taken = 0 → 0x14.
3. Jump pc_control = 10, target 0x0000_0101 → bit 0 cleared, fetch at 0x100. Target 0x0000_0102 → misalign_fault = 1, halted = 1, pc stays at the jump's address, no further imem_req.
4. imem_ack delayed 3 cycles with imem_addr checked each cycle; instr_ready held low 4 cycles in ISSUE → address, instr and pc stable throughout; a stray ack in ISSUE has no effect.
5. imem_rdata = 32'h0000_0000 → illegal_fault = 1, instr = 0x13, HALT. pc_control = 00 on a valid instruction → HALT with no fault. Assert rst_n low mid-FETCH → all reset values immediately, refetch from RESET_PC.
6. pc = 0xFFFF_FFFC, pc_control = 01 → next fetch at 0x0000_0000, pc_plus4 = 0x0 during that instruction.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus: instruction-memory handshake plus the decoder/core-facing
// fields. The fetch unit uses the master side; memory/core use the slave side.
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [4:0]  op_code;
    logic [3:0]  sub_op_code;
    logic [31:0] pc;
    logic [31:0] pc_plus4;

    logic [1:0]  pc_control;
    logic        branch_taken;
    logic [31:0] target_addr;

    logic        misalign_fault;
    logic        illegal_fault;
    logic        halted;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, op_code, sub_op_code,
               pc, pc_plus4, misalign_fault, illegal_fault, halted,
        input  imem_ack, imem_rdata, instr_ready, pc_control, branch_taken, target_addr
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, op_code, sub_op_code,
               pc, pc_plus4, misalign_fault, illegal_fault, halted,
        output imem_ack, imem_rdata, instr_ready, pc_control, branch_taken, target_addr
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, runs the imem req/ack handshake, holds the current
// instruction for the decoder and picks the next PC from the core's pc_control.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                clk,
    input  logic                rst_n,
    instr_fetch_unit_if.master  bus
);

    typedef enum logic [1:0] {START, FETCH, ISSUE, HALT} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc_q, pc_nxt;
    logic [31:0] instr_q, instr_nxt;
    logic        req_q, req_nxt;
    logic        valid_q, valid_nxt;
    logic        halted_q, halted_nxt;
    logic        mis_q, mis_nxt;
    logic        ill_q, ill_nxt;

    logic [31:0] seq_pc, tgt_pc, next_pc;
    logic        redirect, stop;

    assign seq_pc = pc_q + 32'd4;
    // JALR semantics: bit 0 of the target is always cleared.
    assign tgt_pc = bus.target_addr & ~32'd1;

    always_comb begin
        redirect = 1'b0;
        stop     = 1'b0;
        case (bus.pc_control)
            2'b01:   redirect = 1'b0;
            2'b10:   redirect = 1'b1;
            2'b11:   redirect = bus.branch_taken;
            default: stop     = 1'b1;
        endcase
        next_pc = redirect ? tgt_pc : seq_pc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= START;
            pc_q     <= RESET_PC;
            instr_q  <= NOP_INSTR;
            req_q    <= 1'b0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            mis_q    <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc_q     <= pc_nxt;
            instr_q  <= instr_nxt;
            req_q    <= req_nxt;
            valid_q  <= valid_nxt;
            halted_q <= halted_nxt;
            mis_q    <= mis_nxt;
            ill_q    <= ill_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc_q;
        instr_nxt  = instr_q;
        req_nxt    = req_q;
        valid_nxt  = valid_q;
        halted_nxt = halted_q;
        mis_nxt    = mis_q;
        ill_nxt    = ill_q;

        case (state)
            START: begin
                state_nxt = FETCH;
                req_nxt   = 1'b1;
            end

            FETCH: begin
                if (bus.imem_ack) begin
                    req_nxt = 1'b0;
                    if (bus.imem_rdata[1:0] != 2'b11) begin
                        ill_nxt    = 1'b1;
                        instr_nxt  = NOP_INSTR;
                        halted_nxt = 1'b1;
                        state_nxt  = HALT;
                    end else begin
                        instr_nxt = bus.imem_rdata;
                        valid_nxt = 1'b1;
                        state_nxt = ISSUE;
                    end
                end
            end

            ISSUE: begin
                if (bus.instr_ready) begin
                    // A stop or a misaligned redirect both freeze pc on the
                    // offending instruction so it can be inspected after halt.
                    if (stop || (redirect && next_pc[1])) begin
                        mis_nxt    = mis_q | (redirect && next_pc[1]);
                        valid_nxt  = 1'b0;
                        halted_nxt = 1'b1;
                        state_nxt  = HALT;
                    end else begin
                        pc_nxt    = next_pc;
                        valid_nxt = 1'b0;
                        req_nxt   = 1'b1;
                        state_nxt = FETCH;
                    end
                end
            end

            HALT: begin
                req_nxt    = 1'b0;
                valid_nxt  = 1'b0;
                halted_nxt = 1'b1;
            end

            default: state_nxt = START;
        endcase
    end

    assign bus.imem_req       = req_q;
    assign bus.imem_addr      = pc_q;
    assign bus.instr_valid    = valid_q;
    assign bus.instr          = instr_q;
    assign bus.op_code        = instr_q[6:2];
    assign bus.sub_op_code    = {instr_q[30], instr_q[14:12]};
    assign bus.pc             = pc_q;
    assign bus.pc_plus4       = seq_pc;
    assign bus.misalign_fault = mis_q;
    assign bus.illegal_fault  = ill_q;
    assign bus.halted         = halted_q;

endmodule
